// File: rtl/lock_if.sv
// Keypad/comparator-side signals of the lock controller.
// The controller uses the slave modport; the keypad/comparator side uses master.
interface lock_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        cmp_lock;
    logic [11:0] pass_in;
    logic [11:0] pass_set;
    logic        cmp_enb;
    logic        unlocked;
    logic        lockout;
    logic [1:0]  fail_cnt;

    modport master (
        output key_valid, key_code, cmp_lock,
        input  pass_in, pass_set, cmp_enb, unlocked, lockout, fail_cnt
    );

    modport slave (
        input  key_valid, key_code, cmp_lock,
        output pass_in, pass_set, cmp_enb, unlocked, lockout, fail_cnt
    );
endinterface

// File: rtl/lock_controller.sv
// Digital lock sequencer: collects a 3-digit BCD code, runs the external
// comparator, and manages the unlock window, lockout and code re-programming.
module lock_controller #(
    parameter logic [11:0] DEFAULT_PASS   = 12'h123,
    parameter int          MAX_TRIES      = 3,
    parameter int          UNLOCK_CYCLES  = 500,
    parameter int          LOCKOUT_CYCLES = 1000
) (
    input  logic   clk,
    input  logic   rst,
    lock_if.slave  bus
);
    typedef enum logic [2:0] {
        S_ENTRY, S_CHECK1, S_CHECK2, S_OPEN, S_SETNEW, S_LOCKOUT
    } state_t;

    localparam logic [3:0]  K_ENTER  = 4'hA;
    localparam logic [3:0]  K_CLEAR  = 4'hB;
    localparam logic [3:0]  K_SET    = 4'hC;
    localparam logic [15:0] UNLOCK_T = 16'(UNLOCK_CYCLES);
    localparam logic [15:0] LOCK_T   = 16'(LOCKOUT_CYCLES);
    localparam logic [2:0]  MAX_T    = 3'(MAX_TRIES);

    state_t      state_q, state_d;
    logic [11:0] pass_in_q, pass_in_d;
    logic [11:0] pass_set_q, pass_set_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  fail_q, fail_d;
    logic [15:0] timer_q, timer_d;
    logic        cmp_enb_q, cmp_enb_d;
    logic        unlocked_q, unlocked_d;
    logic        lockout_q, lockout_d;

    logic k_digit, k_enter, k_clear, k_set;

    always_comb begin
        k_digit = bus.key_valid && (bus.key_code <= 4'd9);
        k_enter = bus.key_valid && (bus.key_code == K_ENTER);
        k_clear = bus.key_valid && (bus.key_code == K_CLEAR);
        k_set   = bus.key_valid && (bus.key_code == K_SET);
    end

    always_comb begin
        state_d    = state_q;
        pass_in_d  = pass_in_q;
        pass_set_d = pass_set_q;
        cnt_d      = cnt_q;
        fail_d     = fail_q;
        timer_d    = timer_q;

        case (state_q)
            S_ENTRY: begin
                if (k_digit && cnt_q != 2'd3) begin
                    pass_in_d = {pass_in_q[7:0], bus.key_code};
                    cnt_d     = cnt_q + 2'd1;
                end else if (k_enter && cnt_q == 2'd3) begin
                    state_d = S_CHECK1;
                end else if (k_clear) begin
                    pass_in_d = 12'h000;
                    cnt_d     = 2'd0;
                end
            end
            S_CHECK1: state_d = S_CHECK2;
            S_CHECK2: begin
                pass_in_d = 12'h000;
                cnt_d     = 2'd0;
                if (!bus.cmp_lock) begin
                    fail_d  = 2'd0;
                    timer_d = UNLOCK_T;
                    state_d = S_OPEN;
                end else if (({1'b0, fail_q} + 3'd1) == MAX_T) begin
                    fail_d  = MAX_T[1:0];
                    timer_d = LOCK_T;
                    state_d = S_LOCKOUT;
                end else begin
                    fail_d  = fail_q + 2'd1;
                    state_d = S_ENTRY;
                end
            end
            S_OPEN: begin
                // Timer holds the cycles remaining including the current one.
                if (k_clear) begin
                    timer_d = 16'd0;
                    state_d = S_ENTRY;
                end else if (k_set) begin
                    timer_d = 16'd0;
                    state_d = S_SETNEW;
                end else if (timer_q <= 16'd1) begin
                    timer_d = 16'd0;
                    state_d = S_ENTRY;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_SETNEW: begin
                if (k_digit && cnt_q != 2'd3) begin
                    pass_in_d = {pass_in_q[7:0], bus.key_code};
                    cnt_d     = cnt_q + 2'd1;
                end else if (k_enter && cnt_q == 2'd3) begin
                    pass_set_d = pass_in_q;
                    pass_in_d  = 12'h000;
                    cnt_d      = 2'd0;
                    state_d    = S_ENTRY;
                end else if (k_clear) begin
                    pass_in_d = 12'h000;
                    cnt_d     = 2'd0;
                    state_d   = S_ENTRY;
                end
            end
            S_LOCKOUT: begin
                if (timer_q <= 16'd1) begin
                    timer_d = 16'd0;
                    fail_d  = 2'd0;
                    state_d = S_ENTRY;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = S_ENTRY;
        endcase

        // Flags are registered from the next state so they align with it.
        cmp_enb_d  = (state_d == S_CHECK1) || (state_d == S_CHECK2);
        unlocked_d = (state_d == S_OPEN) || (state_d == S_SETNEW);
        lockout_d  = (state_d == S_LOCKOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_ENTRY;
            pass_in_q  <= 12'h000;
            pass_set_q <= DEFAULT_PASS;
            cnt_q      <= 2'd0;
            fail_q     <= 2'd0;
            timer_q    <= 16'd0;
            cmp_enb_q  <= 1'b0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pass_in_q  <= pass_in_d;
            pass_set_q <= pass_set_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            cmp_enb_q  <= cmp_enb_d;
            unlocked_q <= unlocked_d;
            lockout_q  <= lockout_d;
        end
    end

    assign bus.pass_in  = pass_in_q;
    assign bus.pass_set = pass_set_q;
    assign bus.cmp_enb  = cmp_enb_q;
    assign bus.unlocked = unlocked_q;
    assign bus.lockout  = lockout_q;
    assign bus.fail_cnt = fail_q;
endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller: stimulus queues expected output
// changes (value and cycle); a monitor pops one whenever the outputs change.
module tb_lock_controller;
    logic clk;
    logic rst;
    int   cyc;

    lock_if bus ();

    lock_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Comparator model: 0 only when enabled and codes agree.
    assign bus.cmp_lock = !(bus.cmp_enb && (bus.pass_in == bus.pass_set));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic        enb;
        logic        unl;
        logic        lko;
        logic [1:0]  fc;
        logic [11:0] ps;
        logic [11:0] pi;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_ev    = 0;
    logic drain_req  = 1'b0;
    logic drain_done = 1'b0;
    logic first      = 1'b1;
    logic [16:0] prev_t, cur_t;
    exp_t e_m;

    always @(negedge clk) begin
        cur_t = {bus.cmp_enb, bus.unlocked, bus.lockout, bus.fail_cnt, bus.pass_set};
        if (first || cur_t != prev_t) begin
            n_tests++;
            n_ev++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change ev%0d: cyc=%0d enb=%0b unl=%0b lko=%0b fc=%0d ps=%h pi=%h, required no change",
                         n_ev, cyc, bus.cmp_enb, bus.unlocked, bus.lockout, bus.fail_cnt, bus.pass_set, bus.pass_in);
            end else begin
                e_m = exp_q.pop_front();
                if (e_m.cyc != cyc || e_m.enb != bus.cmp_enb || e_m.unl != bus.unlocked ||
                    e_m.lko != bus.lockout || e_m.fc != bus.fail_cnt ||
                    e_m.ps != bus.pass_set || e_m.pi != bus.pass_in) begin
                    n_fail++;
                    $display("FAIL event%0d: got cyc=%0d enb=%0b unl=%0b lko=%0b fc=%0d ps=%h pi=%h, required cyc=%0d enb=%0b unl=%0b lko=%0b fc=%0d ps=%h pi=%h",
                             n_ev, cyc, bus.cmp_enb, bus.unlocked, bus.lockout, bus.fail_cnt, bus.pass_set, bus.pass_in,
                             e_m.cyc, e_m.enb, e_m.unl, e_m.lko, e_m.fc, e_m.ps, e_m.pi);
                end
            end
            prev_t = cur_t;
            first  = 1'b0;
        end
        if (drain_req && !drain_done) begin
            n_tests++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: %0d expected events never seen, first due at cyc=%0d, required 0",
                         exp_q.size(), exp_q[0].cyc);
            end
            drain_done = 1'b1;
        end
        if (cyc > 20000) begin
            $display("FAIL watchdog: cyc=%0d exceeded budget 20000", cyc);
            $fatal(1, "watchdog");
        end
    end

    task automatic expect_at(input int c, input logic enb, input logic unl, input logic lko,
                             input logic [1:0] fc, input logic [11:0] ps, input logic [11:0] pi);
        exp_t e;
        e.cyc = c; e.enb = enb; e.unl = unl; e.lko = lko; e.fc = fc; e.ps = ps; e.pi = pi;
        exp_q.push_back(e);
    endtask

    task automatic key(input logic [3:0] k);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic attempt(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, output int e);
        key(a); key(b); key(c);
        e = cyc;
        key(4'hA);
    endtask

    task automatic do_reset();
        expect_at(cyc, 1'b0, 1'b0, 1'b0, 2'd0, 12'h123, 12'h000);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    // Three wrong attempts with stored code 123; returns ENTER cycle of the last.
    task automatic fail_to_lockout(output int e);
        for (int i = 0; i < 2; i++) begin
            attempt(4'd4, 4'd5, 4'd6, e);
            expect_at(e + 1, 1'b1, 1'b0, 1'b0, 2'(i),     12'h123, 12'h456);
            expect_at(e + 3, 1'b0, 1'b0, 1'b0, 2'(i + 1), 12'h123, 12'h000);
            wait_until(e + 3);
        end
        attempt(4'd4, 4'd5, 4'd6, e);
        expect_at(e + 1, 1'b1, 1'b0, 1'b0, 2'd2, 12'h123, 12'h456);
        expect_at(e + 3, 1'b0, 1'b0, 1'b1, 2'd3, 12'h123, 12'h000);
    endtask

    int e, e2;

    initial begin
        rst = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        #1 rst = 1'b1;
        expect_at(1, 1'b0, 1'b0, 1'b0, 2'd0, 12'h123, 12'h000);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;

        // Correct code, full unlock window.
        attempt(4'd1, 4'd2, 4'd3, e);
        expect_at(e + 1,   1'b1, 1'b0, 1'b0, 2'd0, 12'h123, 12'h123);
        expect_at(e + 3,   1'b0, 1'b1, 1'b0, 2'd0, 12'h123, 12'h000);
        expect_at(e + 503, 1'b0, 1'b0, 1'b0, 2'd0, 12'h123, 12'h000);
        wait_until(e + 503);

        // Three failures into lockout; keys during lockout are ignored.
        fail_to_lockout(e);
        wait_until(e + 10);
        key(4'd7); key(4'd8); key(4'hA); key(4'hC);
        expect_at(e + 1003, 1'b0, 1'b0, 1'b0, 2'd0, 12'h123, 12'h000);
        wait_until(e + 1003);

        // Short ENTER ignored, 4th digit ignored, CLEAR on OPEN cycle 10.
        key(4'd1); key(4'd2); key(4'hA); key(4'hF); key(4'hB);
        key(4'd1); key(4'd2); key(4'd3); key(4'd9);
        e = cyc;
        key(4'hA);
        expect_at(e + 1,  1'b1, 1'b0, 1'b0, 2'd0, 12'h123, 12'h123);
        expect_at(e + 3,  1'b0, 1'b1, 1'b0, 2'd0, 12'h123, 12'h000);
        expect_at(e + 13, 1'b0, 1'b0, 1'b0, 2'd0, 12'h123, 12'h000);
        wait_until(e + 12);
        key(4'hB);

        // CLEAR mid-entry, unlock, then program 789.
        key(4'd1); key(4'd2); key(4'hB);
        attempt(4'd1, 4'd2, 4'd3, e);
        expect_at(e + 1, 1'b1, 1'b0, 1'b0, 2'd0, 12'h123, 12'h123);
        expect_at(e + 3, 1'b0, 1'b1, 1'b0, 2'd0, 12'h123, 12'h000);
        wait_until(e + 3);
        key(4'hC); key(4'd7); key(4'd8); key(4'd9);
        e2 = cyc;
        expect_at(e2 + 1, 1'b0, 1'b0, 1'b0, 2'd0, 12'h789, 12'h000);
        key(4'hA);

        attempt(4'd1, 4'd2, 4'd3, e);
        expect_at(e + 1, 1'b1, 1'b0, 1'b0, 2'd0, 12'h789, 12'h123);
        expect_at(e + 3, 1'b0, 1'b0, 1'b0, 2'd1, 12'h789, 12'h000);
        wait_until(e + 3);
        attempt(4'd7, 4'd8, 4'd9, e);
        expect_at(e + 1, 1'b1, 1'b0, 1'b0, 2'd1, 12'h789, 12'h789);
        expect_at(e + 3, 1'b0, 1'b1, 1'b0, 2'd0, 12'h789, 12'h000);
        wait_until(e + 3);

        // Reset mid-SETNEW restores the default code.
        key(4'hC); key(4'd4); key(4'd5);
        do_reset();

        // Reset mid-LOCKOUT.
        fail_to_lockout(e);
        wait_until(e + 103);
        do_reset();

        attempt(4'd1, 4'd2, 4'd3, e);
        expect_at(e + 1, 1'b1, 1'b0, 1'b0, 2'd0, 12'h123, 12'h123);
        expect_at(e + 3, 1'b0, 1'b1, 1'b0, 2'd0, 12'h123, 12'h000);
        wait_until(e + 6);

        drain_req = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lock_controller.md
# lock_controller

Sequencing controller for the 12-bit code comparator in the digital lock. It collects three BCD digits from the keypad, drives the comparator's entry/stored-code inputs and enable, evaluates the result, and manages the unlock window, failed-attempt counting with lockout, and re-programming of the stored code. It sits between the keypad decoder and the comparator; the status LEDs are driven from its `unlocked`/`lockout` flags.

## Interface
- `DEFAULT_PASS`, 12'h123, stored code after reset, 3 BCD digits.
- `MAX_TRIES`, 3, consecutive failures that trigger lockout; legal range 1..3.
- `UNLOCK_CYCLES`, 500, length of the unlock window in clocks; legal range 1..65535.
- `LOCKOUT_CYCLES`, 1000, length of lockout in clocks; legal range 1..65535.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_valid`  in  1  one-cycle strobe: `key_code` is valid.
- `key_code`  in  4  0–9 digit, 4'hA ENTER, 4'hB CLEAR, 4'hC SET; 4'hD–4'hF are ignored.
- `cmp_lock`  in  1  comparator result: 0 = codes equal while enabled, 1 = mismatch.
- `pass_in`  out  12  entry code to comparator.
- `pass_set`  out  12  stored code to comparator.
- `cmp_enb`  out  1  comparator enable.
- `unlocked`  out  1  high in OPEN and SETNEW.
- `lockout`  out  1  high in LOCKOUT.
- `fail_cnt`  out  2  consecutive failed attempts.

## Operation
- The design has one clock and one reset. Reset is asynchronous and active-high. Reset applies at any time, including mid-operation.
- All outputs are registered.
- Reset values:
  - State: ENTRY.
  - `pass_in` = 0, `pass_set` = `DEFAULT_PASS`, digit count = 0, `fail_cnt` = 0.
  - `cmp_enb` = 0, `unlocked` = 0, `lockout` = 0, timer = 0.
  - A programmed code is lost on reset.
- Digit entry applies in ENTRY and SETNEW:
  - A digit with count < 3 updates `pass_in` <= {`pass_in`[7:0], digit} and increments the count.
  - A digit with count = 3 is ignored.
- ENTRY:
  - ENTER with count = 3 → CHECK1.
  - ENTER with count < 3 is ignored.
  - CLEAR sets `pass_in` and count to 0. `fail_cnt` is unchanged.
  - SET is ignored.
- CHECK1: `cmp_enb` = 1. Next state is CHECK2.
- CHECK2: `cmp_enb` = 1. `cmp_lock` is sampled at the end of this cycle.
  - On match (0): `fail_cnt` <= 0, timer <= `UNLOCK_CYCLES`, next state OPEN.
  - On mismatch with `fail_cnt`+1 = `MAX_TRIES`: timer <= `LOCKOUT_CYCLES`, `fail_cnt` <= `MAX_TRIES`, next state LOCKOUT.
  - Other mismatches: `fail_cnt` increments, next state ENTRY.
  - Leaving CHECK2 always clears `pass_in` and the count.
- OPEN:
  - The timer decrements every cycle. When it reaches 0, next state is ENTRY, so OPEN lasts exactly `UNLOCK_CYCLES` cycles.
  - CLEAR → ENTRY immediately (manual relock).
  - SET → SETNEW. The timer is abandoned.
  - Digits and ENTER are ignored.
- SETNEW:
  - ENTER with count = 3 → `pass_set` <= `pass_in`, then `pass_in` and count clear, next state ENTRY.
  - CLEAR → ENTRY with `pass_set` unchanged.
  - SETNEW has no timeout.
- LOCKOUT:
  - The timer decrements every cycle. When it reaches 0, next state is ENTRY and `fail_cnt` <= 0. LOCKOUT lasts exactly `LOCKOUT_CYCLES` cycles.
  - All keys are ignored.
- Keys arriving in CHECK1/CHECK2 are dropped and never queued.
- Digits are not range-checked beyond 0–9. Codes 4'hD–4'hF never alter state.

## Timing
- A key strobe in cycle N takes effect on `pass_in`, the count, or the state at the edge ending cycle N.
- Comparison latency:
  - Let E be the cycle in which ENTER is strobed.
  - `cmp_enb` is high in cycles E+1 and E+2.
  - `unlocked` or `lockout` rises in cycle E+3 (E+3 for ENTRY on failure).
- `pass_in` holds the full 3-digit code and stays stable throughout CHECK1/CHECK2.
- `unlocked` is high from cycle E+3 through E+2+`UNLOCK_CYCLES`.
- CLEAR in OPEN drops `unlocked` in the following cycle.
- `pass_set` changes only on SETNEW ENTER, with the new value visible in the next cycle, or on reset.

## Test plan
- Reset, then keys 1,2,3,ENTER → `cmp_enb` high for 2 cycles, `unlocked` = 1 for exactly 500 cycles, `fail_cnt` = 0.
- Keys 4,5,6,ENTER three times → `fail_cnt` reads 1, then 2. After the third attempt `lockout` = 1 for 1000 cycles and digits are ignored. Afterwards `fail_cnt` = 0 and state is ENTRY.
- Keys 1,2,3,9,ENTER → the 4th digit is ignored and `pass_in` = 12'h123, so unlock. Keys 1,2,ENTER → no `cmp_enb` pulse and no state change.
- Unlock, then SET,7,8,9,ENTER → `pass_set` = 12'h789. Then 1,2,3,ENTER fails, and 7,8,9,ENTER unlocks.
- Unlock, then CLEAR at cycle 10 of OPEN → `unlocked` drops next cycle. Keys 1,2,CLEAR,1,2,3,ENTER → unlock.
- Assert `rst` mid-LOCKOUT and mid-SETNEW → all outputs return to reset values, including `pass_set` = 12'h123.
